// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of pending stores, drained to dmem port B
// whenever no load needs the memory, with youngest-match forwarding to loads.
module store_buffer #(
    parameter int DATA_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [15:0]       st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_valid,
    input  logic [15:0]       ld_addr,
    output logic              ld_data_valid,
    output logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    output logic              empty,
    output logic [2:0]        count,
    output logic [15:0]       dm_a_a,
    input  logic [DATA_W-1:0] dm_rd_a,
    output logic [15:0]       dm_a_b,
    output logic [DATA_W-1:0] dm_wd_b,
    output logic              dm_we_b,
    output logic              dm_we_a
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

    logic [15:0]       addr_q [SB_DEPTH];
    logic [15:0]       addr_d [SB_DEPTH];
    logic [DATA_W-1:0] data_q [SB_DEPTH];
    logic [DATA_W-1:0] data_d [SB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ld_data_valid_q, ld_data_valid_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic              enq;
    logic              drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign st_ready = (count_q < FULL_CNT);
    assign enq      = st_valid && st_ready;
    // Loads own the memory unless flush forces the head entry out anyway.
    assign drain    = (count_q != '0) && (!ld_valid || flush);

    // Walk live entries oldest to youngest so the last match wins; the entry
    // draining this cycle is still live, the one enqueuing is not yet.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        addr_d          = addr_q;
        data_d          = data_q;
        ld_data_valid_d = ld_valid;
        ld_data_d       = ld_data_q;

        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            addr_d[tail_q] = st_addr;
            data_d[tail_q] = st_data;
            tail_d         = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(drain);

        if (ld_valid) begin
            ld_data_d = fwd_hit ? fwd_data : dm_rd_a;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            ld_data_valid_q <= 1'b0;
            ld_data_q       <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            ld_data_valid_q <= ld_data_valid_d;
            ld_data_q       <= ld_data_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count/head/tail alone decide which entries are live.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign ld_data_valid = ld_data_valid_q;
    assign ld_data       = ld_data_q;
    assign dm_a_a        = ld_addr;
    assign dm_we_a       = 1'b0;
    assign dm_a_b        = addr_q[head_q];
    assign dm_wd_b       = data_q[head_q];
    assign dm_we_b       = drain;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of pending stores and a reference memory.
module tb_store_buffer;
    localparam int DW = 32;

    typedef struct {
        logic [15:0]   addr;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [15:0]   st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          ld_valid = 1'b0;
    logic [15:0]   ld_addr = '0;
    logic          ld_data_valid;
    logic [DW-1:0] ld_data;
    logic          flush = 1'b0;
    logic          empty;
    logic [2:0]    count;
    logic [15:0]   dm_a_a;
    logic [DW-1:0] dm_rd_a;
    logic [15:0]   dm_a_b;
    logic [DW-1:0] dm_wd_b;
    logic          dm_we_b;
    logic          dm_we_a;

    store_buffer #(.DATA_W(DW), .SB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .flush(flush), .empty(empty), .count(count),
        .dm_a_a(dm_a_a), .dm_rd_a(dm_rd_a),
        .dm_a_b(dm_a_b), .dm_wd_b(dm_wd_b), .dm_we_b(dm_we_b), .dm_we_a(dm_we_a)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [15:0] a);
        return (a == 16'h0030) ? 32'h0000_1234 : {~a, a};
    endfunction

    // Memory seen by the DUT: only words the DUT has written differ from init_val.
    logic [DW-1:0] dut_mem [65536];
    bit            dut_wr  [65536];
    assign dm_rd_a = dut_wr[dm_a_a] ? dut_mem[dm_a_a] : init_val(dm_a_a);
    always @(posedge clk) begin
        if (dm_we_b) begin
            dut_mem[dm_a_b] <= dm_wd_b;
            dut_wr[dm_a_b]  <= 1'b1;
        end
    end

    // Reference model: pending stores oldest-first, plus the memory they drain into.
    entry_t        sbq[$];
    logic [DW-1:0] ref_mem [logic [15:0]];
    logic          exp_ldv = 1'b0;
    logic [DW-1:0] exp_ldd = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] dut_rd(input logic [15:0] a);
        return dut_wr[a] ? dut_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational response, then advance the model to the next edge.
    task automatic step(input logic sv, input logic [15:0] sa, input logic [DW-1:0] sd,
                        input logic lv, input logic [15:0] la, input logic fl);
        logic          exp_drain;
        logic          exp_ready;
        logic [DW-1:0] res;
        @(negedge clk);
        check("ld_data_valid", DW'(ld_data_valid), DW'(exp_ldv));
        check("ld_data", ld_data, exp_ldd);
        check("count", DW'(count), DW'(sbq.size()));
        check("empty", DW'(empty), DW'(sbq.size() == 0));
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; flush = fl;
        #1;
        exp_ready = (sbq.size() < 4);
        exp_drain = (sbq.size() > 0) && (!lv || fl);
        check("st_ready", DW'(st_ready), DW'(exp_ready));
        check("dm_we_b", DW'(dm_we_b), DW'(exp_drain));
        check("dm_we_a", DW'(dm_we_a), '0);
        check("dm_a_a", DW'(dm_a_a), DW'(la));
        if (sbq.size() > 0) begin
            check("dm_a_b", DW'(dm_a_b), DW'(sbq[0].addr));
            check("dm_wd_b", dm_wd_b, sbq[0].data);
        end
        if (lv) begin
            res = ref_rd(la);
            foreach (sbq[i]) if (sbq[i].addr == la) res = sbq[i].data;
            exp_ldd = res;
        end
        exp_ldv = lv;
        if (exp_drain) begin
            ref_mem[sbq[0].addr] = sbq[0].data;
            void'(sbq.pop_front());
        end
        if (sv && exp_ready) sbq.push_back('{addr: sa, data: sd});
    endtask

    task automatic idle();
        step(1'b0, 16'h0, '0, 1'b0, 16'h0, 1'b0);
    endtask

    // Asynchronous reset between clock edges; pending stores must vanish unwritten.
    task automatic apply_reset();
        logic [15:0] lost[$];
        @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", DW'(count), '0);
        check("rst_empty", DW'(empty), DW'(1));
        check("rst_st_ready", DW'(st_ready), DW'(1));
        check("rst_dm_we_b", DW'(dm_we_b), '0);
        check("rst_ld_data_valid", DW'(ld_data_valid), '0);
        check("rst_ld_data", ld_data, '0);
        foreach (sbq[i]) lost.push_back(sbq[i].addr);
        sbq.delete();
        exp_ldv = 1'b0;
        exp_ldd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (lost[i]) check("rst_no_write", dut_rd(lost[i]), ref_rd(lost[i]));
    endtask

    initial begin
        apply_reset();

        // Fill with loads holding off the drain; the fifth store must stall.
        for (int i = 0; i < 5; i++) step(1'b1, 16'h10 + 16'(i), 32'h100 + DW'(i), 1'b1, 16'h12, 1'b0);
        check("fill_count", DW'(count), DW'(4));
        check("fill_st_ready", DW'(st_ready), '0);

        // Drain in FIFO order once loads stop.
        for (int i = 0; i < 4; i++) begin
            idle();
            check("drain_we", DW'(dm_we_b), DW'(1));
            check("drain_addr", DW'(dm_a_b), DW'(16'h10 + 16'(i)));
        end
        idle();
        check("drain_empty", DW'(empty), DW'(1));

        // Youngest of two pending stores to the same address is forwarded.
        step(1'b1, 16'h20, 32'hAAAA, 1'b1, 16'h99, 1'b0);
        step(1'b1, 16'h20, 32'hBBBB, 1'b1, 16'h99, 1'b0);
        step(1'b0, 16'h0, '0, 1'b1, 16'h20, 1'b0);
        idle();
        check("fwd_youngest_data", ld_data, 32'hBBBB);
        check("fwd_youngest_valid", DW'(ld_data_valid), DW'(1));
        idle();

        // A store in the same cycle as the load is not visible to it.
        step(1'b1, 16'h30, 32'hDEAD, 1'b1, 16'h30, 1'b0);
        idle();
        check("same_cycle_ld", ld_data, 32'h1234);
        idle();
        idle();

        // Flush drains under loads, including forwarding from the draining head.
        step(1'b1, 16'h50, 32'h5050, 1'b1, 16'h99, 1'b0);
        step(1'b1, 16'h51, 32'h5151, 1'b1, 16'h99, 1'b0);
        step(1'b0, 16'h0, '0, 1'b1, 16'h50, 1'b1);
        check("flush_we_0", DW'(dm_we_b), DW'(1));
        step(1'b0, 16'h0, '0, 1'b1, 16'h51, 1'b1);
        check("flush_we_1", DW'(dm_we_b), DW'(1));
        idle();
        check("flush_ld", ld_data, 32'h5151);
        step(1'b0, 16'h0, '0, 1'b1, 16'h50, 1'b0);
        idle();
        check("post_flush_ld", ld_data, 32'h5050);

        // Reset with three stores pending.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h60 + 16'(i), 32'h600 + DW'(i), 1'b1, 16'h99, 1'b0);
        apply_reset();
        idle();

        // Random traffic over a small address window to provoke hits and full stalls.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 16'h40 + 16'($urandom_range(0, 7)), DW'($urandom),
                 $urandom_range(0, 99) < 50, 16'h40 + 16'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 10);
        end
        for (int i = 0; i < 6; i++) idle();
        for (int a = 16'h40; a < 16'h48; a++) check("final_mem", dut_rd(16'(a)), ref_rd(16'(a)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
